// File: rtl/grf_hazard_ctrl.sv
// rtl/grf_hazard_ctrl.sv - register file scoreboard, stall and D-stage forwarding control
//
// Purpose:
//   Tracks the destination register and remaining result latency (Tnew) of the
//   instructions in E, M and W. Compares them against the read requirements
//   (Tuse) of the instruction in D. Produces the pipeline stall, the D-stage
//   forwarding selects and the W-stage register file write-port controls.
//
// Optional feature:
//   GRF_HAZARD_STAT_EN - adds the stall_cnt output, a free-running count of
//   stalled cycles, and a trace line on every stalled edge.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   d_valid             D stage holds a real instruction
//   d_rs, d_rt          source register addresses of the D instruction
//   d_rs_use, d_rt_use  D instruction actually reads rs / rt
//   d_tuse_rs/rt        cycles until rs / rt is consumed (0 = consumed in D)
//   d_a3, d_tnew        destination (0 = none) and result latency from E entry
//   stall               freeze PC and F/D, insert a bubble into E
//   fwd_rs/rt_sel       0 = register file, 1 = E result, 2 = M result
//   w_en, w_a3          register file write port for the W instruction
//   stall_cnt           stalled-cycle count (GRF_HAZARD_STAT_EN only)

module grf_hazard_ctrl #(
  parameter int TNEW_W = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
`ifdef GRF_HAZARD_STAT_EN
  output logic [STAT_W-1:0] stall_cnt,
`endif
  output logic              w_en,
  output logic [4:0]        w_a3
);

  // Stage records
  logic              e_valid_q, e_valid_d;
  logic [4:0]        e_a3_q,    e_a3_d;
  logic [TNEW_W-1:0] e_tnew_q,  e_tnew_d;
  logic              m_valid_q, m_valid_d;
  logic [4:0]        m_a3_q,    m_a3_d;
  logic [TNEW_W-1:0] m_tnew_q,  m_tnew_d;
  logic              w_valid_q, w_valid_d;
  logic [4:0]        w_a3_q,    w_a3_d;

  // Tnew counts down as the record moves on but never wraps below zero.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  // Register 0 is hard-wired, so it never creates a dependency.
  logic e_rs_match, m_rs_match, e_rt_match, m_rt_match;
  assign e_rs_match = e_valid_q && d_rs_use && (d_rs != 5'd0) && (e_a3_q == d_rs);
  assign m_rs_match = m_valid_q && d_rs_use && (d_rs != 5'd0) && (m_a3_q == d_rs);
  assign e_rt_match = e_valid_q && d_rt_use && (d_rt != 5'd0) && (e_a3_q == d_rt);
  assign m_rt_match = m_valid_q && d_rt_use && (d_rt != 5'd0) && (m_a3_q == d_rt);

  // A producer stalls D only if its result arrives later than D needs it.
  // W is absent here: the register file passes same-cycle writes through.
  logic hz_rs, hz_rt;
  assign hz_rs = (e_rs_match && (e_tnew_q > d_tuse_rs)) ||
                 (m_rs_match && (m_tnew_q > d_tuse_rs));
  assign hz_rt = (e_rt_match && (e_tnew_q > d_tuse_rt)) ||
                 (m_rt_match && (m_tnew_q > d_tuse_rt));
  assign stall = d_valid && (hz_rs || hz_rt);

  // Only a result that already exists (tnew == 0) can be forwarded;
  // the younger producer in E holds the newer value and wins over M.
  always_comb begin
    fwd_rs_sel = 2'd0;
    if (e_rs_match && (e_tnew_q == '0)) begin
      fwd_rs_sel = 2'd1;
    end else if (m_rs_match && (m_tnew_q == '0)) begin
      fwd_rs_sel = 2'd2;
    end
  end

  always_comb begin
    fwd_rt_sel = 2'd0;
    if (e_rt_match && (e_tnew_q == '0)) begin
      fwd_rt_sel = 2'd1;
    end else if (m_rt_match && (m_tnew_q == '0)) begin
      fwd_rt_sel = 2'd2;
    end
  end

  // M and W always advance; only the E entry depends on the stall, so a
  // stall resolves by itself as the producer drains towards W.
  always_comb begin
    w_valid_d = m_valid_q;
    w_a3_d    = m_a3_q;
    m_valid_d = e_valid_q;
    m_a3_d    = e_a3_q;
    m_tnew_d  = sat_dec(e_tnew_q);
    e_valid_d = 1'b0;
    e_a3_d    = 5'd0;
    e_tnew_d  = '0;
    if (!stall && d_valid) begin
      e_valid_d = 1'b1;
      e_a3_d    = d_a3;
      e_tnew_d  = d_tnew;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_a3_q    <= 5'd0;
      e_tnew_q  <= '0;
      m_valid_q <= 1'b0;
      m_a3_q    <= 5'd0;
      m_tnew_q  <= '0;
      w_valid_q <= 1'b0;
      w_a3_q    <= 5'd0;
    end else begin
      e_valid_q <= e_valid_d;
      e_a3_q    <= e_a3_d;
      e_tnew_q  <= e_tnew_d;
      m_valid_q <= m_valid_d;
      m_a3_q    <= m_a3_d;
      m_tnew_q  <= m_tnew_d;
      w_valid_q <= w_valid_d;
      w_a3_q    <= w_a3_d;
    end
  end

  // A valid instruction without a destination still flows but never writes.
  assign w_en = w_valid_q && (w_a3_q != 5'd0);
  assign w_a3 = w_a3_q;

`ifdef GRF_HAZARD_STAT_EN
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      $display("%d@stall rs=%d rt=%d", $time, d_rs, d_rt);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// tb/tb_grf_hazard_ctrl.sv - directed self-checking bench for grf_hazard_ctrl

module tb_grf_hazard_ctrl;

  localparam int TNEW_W = 2;
  localparam int STAT_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              d_valid;
  logic [4:0]        d_rs, d_rt, d_a3;
  logic              d_rs_use, d_rt_use;
  logic [TNEW_W-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic              stall;
  logic [1:0]        fwd_rs_sel, fwd_rt_sel;
  logic              w_en;
  logic [4:0]        w_a3;
`ifdef GRF_HAZARD_STAT_EN
  logic [STAT_W-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  grf_hazard_ctrl #(.TNEW_W(TNEW_W), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_use   (d_rs_use),
    .d_rt_use   (d_rt_use),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
`ifdef GRF_HAZARD_STAT_EN
    .stall_cnt  (stall_cnt),
`endif
    .w_en       (w_en),
    .w_a3       (w_a3)
  );

  int checks = 0;
  int errors = 0;

  // Expected W-stage output {w_en, w_a3} for every record entering E.
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] a3, input logic [1:0] tn);
    d_valid   = v;
    d_rs      = rs;
    d_rt      = rt;
    d_rs_use  = rsu;
    d_rt_use  = rtu;
    d_tuse_rs = trs;
    d_tuse_rt = trt;
    d_a3      = a3;
    d_tnew    = tn;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
  endtask

  // One pipeline cycle: check combinational outputs mid-cycle (a negative
  // select means "not checked"), clock, then pop the W expectation that
  // should now be visible three records back.
  task automatic cyc(input string tag, input logic exp_stall, input int exp_rs, input int exp_rt);
    logic [5:0] ent;
    logic [5:0] w_exp;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    if (exp_rs >= 0) chk({tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(exp_rs));
    if (exp_rt >= 0) chk({tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(exp_rt));
    ent = (exp_stall || !d_valid) ? 6'd0 : {(d_a3 != 5'd0), d_a3};
    @(posedge clk);
    exp_q.push_back(ent);
    #1;
    if (exp_q.size() >= 3) begin
      w_exp = exp_q.pop_front();
      chk({tag, ".w_en"}, 32'(w_en), 32'(w_exp[5]));
      chk({tag, ".w_a3"}, 32'(w_a3), 32'(w_exp[4:0]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    nop();
    #1 reset = 1'b1;
    #2;
    chk("rst.stall",  32'(stall),      32'd0);
    chk("rst.fwd_rs", 32'(fwd_rs_sel), 32'd0);
    chk("rst.fwd_rt", 32'(fwd_rt_sel), 32'd0);
    chk("rst.w_en",   32'(w_en),       32'd0);
    chk("rst.w_a3",   32'(w_a3),       32'd0);
`ifdef GRF_HAZARD_STAT_EN
    chk("rst.cnt",    stall_cnt,       32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(6'd0);
    exp_q.push_back(6'd0);

    // W path: a3=9 appears after the 3rd edge, gone after the 4th
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd9, 2'd0);
    cyc("wpath", 1'b0, 0, 0);
    nop();
    for (int i = 0; i < 4; i++) cyc("wpath_nop", 1'b0, 0, 0);

    // Load-use: lw $1 then addu $2,$1,$3
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd1, 2'd2);
    cyc("lw1", 1'b0, 0, 0);
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1, 5'd2, 2'd1);
    cyc("lu_stall", 1'b1, 0, 0);
    cyc("lu_go", 1'b0, -1, 0);

    // ALU back-to-back: addu $4 then beq $4,$0
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd4, 2'd1);
    cyc("addu4", 1'b0, 0, 0);
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 2'd0);
    cyc("alu_stall", 1'b1, 0, 0);
    cyc("alu_fwd", 1'b0, 2, 0);

    // ALU producer, consumer with tuse_rs=1: no stall
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd6, 2'd1);
    cyc("addu6", 1'b0, 0, 0);
    drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd7, 2'd1);
    cyc("alu_t1", 1'b0, -1, 0);

    // Register 0 never matches and never writes
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd2);
    cyc("r0_prod", 1'b0, 0, 0);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    cyc("r0_use", 1'b0, 0, 0);

    // Priority: $5 ready in both E and M, E wins; rs == rt gives equal selects
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd5, 2'd0);
    cyc("p5a", 1'b0, 0, 0);
    cyc("p5b", 1'b0, 0, 0);
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 2'd2, 2'd0, 5'd0, 2'd0);
    cyc("prio", 1'b0, 1, 1);

    // Stall raised from M, never from W
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd8, 2'd2);
    cyc("lw8", 1'b0, 0, 0);
    nop();
    cyc("lw8_nop", 1'b0, 0, 0);
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0);
    cyc("m_stall", 1'b1, 0, 0);
    cyc("w_nostall", 1'b0, 0, 0);

    // Invalid D never stalls
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd10, 2'd2);
    cyc("lw10", 1'b0, 0, 0);
    drive(1'b0, 5'd10, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 5'd3, 2'd0);
    cyc("inv_d", 1'b0, 0, 0);

    // rs hazard on M and rt hazard on E together, then reset mid-stall
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd11, 2'd2);
    cyc("lw11", 1'b0, 0, 0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd12, 2'd3);
    cyc("lw12", 1'b0, 0, 0);
    drive(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 2'd0, 2'd0, 5'd0, 2'd0);
    cyc("both", 1'b1, 0, 0);
    @(negedge clk);
    chk("pre_rst.stall", 32'(stall), 32'd1);
    chk("pre_rst.w_en",  32'(w_en),  32'd1);
    chk("pre_rst.w_a3",  32'(w_a3),  32'd11);
`ifdef GRF_HAZARD_STAT_EN
    chk("pre_rst.cnt",   stall_cnt,  32'd4);
`endif
    #2 reset = 1'b1;
    #1;
    chk("mid_rst.stall",  32'(stall),      32'd0);
    chk("mid_rst.fwd_rs", 32'(fwd_rs_sel), 32'd0);
    chk("mid_rst.fwd_rt", 32'(fwd_rt_sel), 32'd0);
    chk("mid_rst.w_en",   32'(w_en),       32'd0);
    chk("mid_rst.w_a3",   32'(w_a3),       32'd0);
`ifdef GRF_HAZARD_STAT_EN
    chk("mid_rst.cnt",    stall_cnt,       32'd0);
`endif
    nop();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(6'd0);
    exp_q.push_back(6'd0);

    // Pipeline works again after reset
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd1, 2'd2);
    cyc("post_lw", 1'b0, 0, 0);
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 5'd2, 2'd1);
    cyc("post_stall", 1'b1, 0, 0);
    nop();
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
